key_debounce_event: RTL

//  Input-side companion of the buzzer driver. Synchronises and debounces KEY_NUM
//  raw push-buttons and emits one-cycle press/release events plus a one-cycle

---
 rtl/key_debounce_event.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/key_debounce_event.sv
// Key synchroniser, per-key debounce FSM and registered press/release/beep event outputs.
// An accept decision is staged in ev_*_q, then the output stage presents all events together.
module key_debounce_event #(
    parameter int unsigned KEY_NUM       = 4,
    parameter int unsigned DEBOUNCE_TIME = 1_000_000,
    parameter logic        KEY_ACTIVE    = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [KEY_NUM-1:0] key_in,
    output logic [KEY_NUM-1:0] key_state,
    output logic [KEY_NUM-1:0] key_press,
    output logic [KEY_NUM-1:0] key_release,
    output logic [2:0]         key_code,
    output logic               key_valid,
    output logic               beep_flag
);
    localparam int unsigned CW = $clog2(DEBOUNCE_TIME + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_TIME - 1);

    localparam logic [1:0] S_RELEASED    = 2'd0;
    localparam logic [1:0] S_PRESS_DEB   = 2'd1;
    localparam logic [1:0] S_PRESSED     = 2'd2;
    localparam logic [1:0] S_RELEASE_DEB = 2'd3;

    logic [KEY_NUM-1:0] sync1_q, sync2_q;
    logic [KEY_NUM-1:0] ev_press_d, ev_release_d;
    logic [KEY_NUM-1:0] ev_press_q, ev_release_q;
    logic [KEY_NUM-1:0] key_state_q, key_press_q, key_release_q;
    logic [2:0]         key_code_q, key_code_d;
    logic               key_valid_q, beep_flag_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= {KEY_NUM{~KEY_ACTIVE}};
            sync2_q <= {KEY_NUM{~KEY_ACTIVE}};
        end else begin
            sync1_q <= key_in;
            sync2_q <= sync1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < KEY_NUM; gi++) begin : g_key
            logic [1:0]    st_q, st_d;
            logic [CW-1:0] cnt_q, cnt_d;
            logic          p, acc_press, acc_release;

            assign p = (sync2_q[gi] == KEY_ACTIVE);

            // A bounce back to the old level discards all debounce progress.
            always_comb begin
                st_d        = st_q;
                cnt_d       = cnt_q;
                acc_press   = 1'b0;
                acc_release = 1'b0;
                case (st_q)
                    S_RELEASED: begin
                        if (p) begin
                            st_d  = S_PRESS_DEB;
                            cnt_d = CW'(1);
                        end
                    end
                    S_PRESS_DEB: begin
                        if (!p) begin
                            st_d  = S_RELEASED;
                            cnt_d = '0;
                        end else if (cnt_q == DEB_LAST) begin
                            st_d      = S_PRESSED;
                            cnt_d     = '0;
                            acc_press = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                    S_PRESSED: begin
                        if (!p) begin
                            st_d  = S_RELEASE_DEB;
                            cnt_d = CW'(1);
                        end
                    end
                    default: begin
                        if (p) begin
                            st_d  = S_PRESSED;
                            cnt_d = '0;
                        end else if (cnt_q == DEB_LAST) begin
                            st_d        = S_RELEASED;
                            cnt_d       = '0;
                            acc_release = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                endcase
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    st_q  <= S_RELEASED;
                    cnt_q <= '0;
                end else begin
                    st_q  <= st_d;
                    cnt_q <= cnt_d;
                end
            end

            assign ev_press_d[gi]   = acc_press;
            assign ev_release_d[gi] = acc_release;
        end
    endgenerate

    always_comb begin
        key_code_d = 3'd0;
        for (int i = KEY_NUM - 1; i >= 0; i--) begin
            if (ev_press_q[i]) key_code_d = 3'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ev_press_q    <= '0;
            ev_release_q  <= '0;
            key_state_q   <= '0;
            key_press_q   <= '0;
            key_release_q <= '0;
            key_code_q    <= 3'd0;
            key_valid_q   <= 1'b0;
            beep_flag_q   <= 1'b0;
        end else begin
            ev_press_q    <= ev_press_d;
            ev_release_q  <= ev_release_d;
            key_state_q   <= (key_state_q | ev_press_q) & ~ev_release_q;
            key_press_q   <= ev_press_q;
            key_release_q <= ev_release_q;
            key_code_q    <= key_code_d;
            key_valid_q   <= |ev_press_q;
            beep_flag_q   <= |ev_press_q;
        end
    end

    assign key_state   = key_state_q;
    assign key_press   = key_press_q;
    assign key_release = key_release_q;
    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign beep_flag   = beep_flag_q;
endmodule
